truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper.sv | 188 ++++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: exhaustive N-input stimulus engine that checks a
// DUT against X = A & ~(B ^ C ^ ...) and records the observed table.
module truth_table_sweeper #(
  parameter int N   = 3,
  parameter int LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  output logic [N-1:0]       vec,
  output logic               vec_valid,
  input  logic               dut_x,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N:0]         err_count,
  output logic [N-1:0]       first_fail,
  output logic               fail_seen,
  output logic [(1<<N)-1:0]  obs_table
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        cnt_q, cnt_d;
  logic [2:0]          drain_q, drain_d;
  logic                mode_q, mode_d;
  logic [N-1:0]        vec_q, vec_d;
  logic                vec_valid_q, vec_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [N:0]          err_count_q, err_count_d;
  logic [N-1:0]        first_fail_q, first_fail_d;
  logic                fail_seen_q, fail_seen_d;
  logic [(1<<N)-1:0]   obs_table_q, obs_table_d;

  logic                cmp_valid;
  logic [N-1:0]        cmp_vec;
  logic                exp_bit;
  logic [N-1:0]        cnt_nxt;

  // Vector issued k cycles ago lines up with dut_x when k == LAT.
  if (LAT == 0) begin : g_nopipe
    assign cmp_valid = vec_valid_q;
    assign cmp_vec   = vec_q;
  end else begin : g_pipe
    logic [LAT-1:0] pv_q;
    logic [N-1:0]   pvec_q [LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        pv_q <= '0;
        for (int i = 0; i < LAT; i++) pvec_q[i] <= '0;
      end else begin
        pv_q[0]   <= vec_valid_q;
        pvec_q[0] <= vec_q;
        for (int i = 1; i < LAT; i++) begin
          pv_q[i]   <= pv_q[i-1];
          pvec_q[i] <= pvec_q[i-1];
        end
      end
    end

    assign cmp_valid = pv_q[LAT-1];
    assign cmp_vec   = pvec_q[LAT-1];
  end

  assign exp_bit = cmp_vec[N-1] & ~(^cmp_vec[N-2:0]);
  assign cnt_nxt = cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drain_d      = drain_q;
    mode_d       = mode_q;
    vec_d        = vec_q;
    vec_valid_d  = vec_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    fail_seen_d  = fail_seen_q;
    obs_table_d  = obs_table_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          cnt_d        = '0;
          mode_d       = mode;
          vec_d        = '0;
          vec_valid_d  = 1'b1;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          err_count_d  = '0;
          first_fail_d = '0;
          fail_seen_d  = 1'b0;
          obs_table_d  = '0;
        end
      end
      RUN: begin
        if (cnt_q == {N{1'b1}}) begin
          state_d     = DRAIN;
          vec_valid_d = 1'b0;
          drain_d     = '0;
        end else begin
          cnt_d = cnt_nxt;
          vec_d = mode_q ? (cnt_nxt ^ (cnt_nxt >> 1)) : cnt_nxt;
        end
      end
      DRAIN: begin
        if (drain_q == 3'(LAT)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_q == '0);
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    if (cmp_valid) begin
      obs_table_d[cmp_vec] = dut_x;
      if (dut_x != exp_bit) begin
        err_count_d = err_count_q + 1'b1;
        if (!fail_seen_q) begin
          fail_seen_d  = 1'b1;
          first_fail_d = cmp_vec;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      drain_q      <= '0;
      mode_q       <= 1'b0;
      vec_q        <= '0;
      vec_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
      obs_table_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      mode_q       <= mode_d;
      vec_q        <= vec_d;
      vec_valid_q  <= vec_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
      fail_seen_q  <= fail_seen_d;
      obs_table_q  <= obs_table_d;
    end
  end

  assign vec        = vec_q;
  assign vec_valid  = vec_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign first_fail = first_fail_q;
  assign fail_seen  = fail_seen_q;
  assign obs_table  = obs_table_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed sweeps against LAT=1 and LAT=0
// instances with correct, stuck-at-0 and stuck-at-1 DUT models.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_tbl = 8'b1001_0000;

  int nvec = 0;
  int nmis = 0;

  logic       rst1, start1, mode1, dut_x1;
  logic [2:0] vec1, ff1;
  logic       vld1, busy1, done1, pass1, fs1;
  logic [3:0] err1;
  logic [7:0] obs1;
  int         kind1;
  logic       reg_x1;

  always @(posedge clk) reg_x1 <= exp_tbl[vec1];
  assign dut_x1 = (kind1 == 0) ? reg_x1 : (kind1 == 2);

  truth_table_sweeper #(.N(3), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .mode(mode1),
    .vec(vec1), .vec_valid(vld1), .dut_x(dut_x1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail(ff1), .fail_seen(fs1),
    .obs_table(obs1)
  );

  logic       rst0, start0, mode0, dut_x0;
  logic [2:0] vec0, ff0;
  logic       vld0, busy0, done0, pass0, fs0;
  logic [3:0] err0;
  logic [7:0] obs0;

  assign dut_x0 = exp_tbl[vec0];

  truth_table_sweeper #(.N(3), .LAT(0)) u_dut0 (
    .clk(clk), .rst(rst0), .start(start0), .mode(mode0),
    .vec(vec0), .vec_valid(vld0), .dut_x(dut_x0),
    .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail(ff0), .fail_seen(fs0),
    .obs_table(obs0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  int          dcyc, ndone;
  logic [23:0] seq;
  logic        bz10, bz11;

  // Called just after a posedge: that cycle is cycle 0.
  task automatic run1(input logic m, input int k);
    kind1  = k;
    mode1  = m;
    start1 = 1'b1;
    dcyc   = -1;
    ndone  = 0;
    seq    = '0;
    bz10   = 1'b0;
    bz11   = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      start1 = 1'b0;
      if (c == 3) mode1 = ~m;
      if (vld1) seq = {seq[20:0], vec1};
      if (done1) begin
        ndone++;
        dcyc = c;
      end
      if (c == 10) bz10 = busy1;
      if (c == 11) bz11 = busy1;
    end
  endtask

  initial begin
    rst1 = 1'b1; start1 = 1'b0; mode1 = 1'b0; kind1 = 0;
    rst0 = 1'b1; start0 = 1'b0; mode0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst1_outs",
        {vec1, vld1, busy1, done1, pass1, err1, ff1, fs1, obs1}, 32'h0);
    chk("rst0_outs",
        {vec0, vld0, busy0, done0, pass0, err0, ff0, fs0, obs0}, 32'h0);
    rst1 = 1'b0;
    rst0 = 1'b0;
    @(posedge clk);
    #1;

    run1(1'b0, 0);
    chk("ok_err", err1, 0);
    chk("ok_pass", pass1, 1);
    chk("ok_fs", fs1, 0);
    chk("ok_obs", obs1, 8'b1001_0000);
    chk("ok_done_cyc", dcyc, 11);
    chk("ok_ndone", ndone, 1);
    chk("ok_busy10", bz10, 1);
    chk("ok_busy11", bz11, 0);
    chk("ok_seq", seq, 24'o01234567);

    run1(1'b0, 1);
    chk("s0_err", err1, 2);
    chk("s0_ff", ff1, 4);
    chk("s0_fs", fs1, 1);
    chk("s0_pass", pass1, 0);
    chk("s0_obs", obs1, 8'h00);

    run1(1'b0, 2);
    chk("s1_err", err1, 6);
    chk("s1_ff", ff1, 0);
    chk("s1_obs", obs1, 8'hFF);
    chk("s1_pass", pass1, 0);

    run1(1'b1, 1);
    chk("gray_seq", seq, 24'o01326754);
    chk("gray_ff", ff1, 7);
    chk("gray_err", err1, 2);
    chk("gray_done_cyc", dcyc, 11);

    // Reset mid-sweep, then a clean re-run.
    kind1  = 1;
    mode1  = 1'b0;
    start1 = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      start1 = 1'b0;
    end
    chk("mid_busy", busy1, 1);
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_outs",
        {vec1, vld1, busy1, done1, pass1, err1, ff1, fs1, obs1}, 32'h0);
    rst1 = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", busy1, 0);
    run1(1'b0, 1);
    chk("rerun_err", err1, 2);
    chk("rerun_done_cyc", dcyc, 11);
    chk("rerun_seq", seq, 24'o01234567);

    // LAT=0 with start pulses during cycles 2..9.
    dcyc   = -1;
    ndone  = 0;
    bz11   = 1'b1;
    start0 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      start0 = (c >= 2 && c <= 9);
      if (done0) begin
        ndone++;
        dcyc = c;
      end
      if (c == 11) bz11 = busy0;
    end
    chk("l0_pass", pass0, 1);
    chk("l0_err", err0, 0);
    chk("l0_obs", obs0, 8'b1001_0000);
    chk("l0_done_cyc", dcyc, 10);
    chk("l0_ndone", ndone, 1);
    chk("l0_busy11", bz11, 0);
    chk("l0_busy_end", busy0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
